// File: rtl/rr_req_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
interface rr_req_arbiter_if #(
  parameter int unsigned ID_W = 2
);
  localparam int unsigned REQ_NUM = 32'(1) << ID_W;

  logic [REQ_NUM-1:0] req;
  logic [REQ_NUM-1:0] done;
  logic [REQ_NUM-1:0] gnt;
  logic               gnt_vld;
  logic [ID_W-1:0]    gnt_id;
  logic               timeout;
  logic               busy;

  // Requester side drives req/done and observes the grant.
  modport master (
    output req, done,
    input  gnt, gnt_vld, gnt_id, timeout, busy
  );

  // Arbiter side observes req/done and drives the grant.
  modport slave (
    input  req, done,
    output gnt, gnt_vld, gnt_id, timeout, busy
  );
endinterface

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter: locks a one-hot grant to one owner until done, request
// drop or hold limit; every release passes through one idle cycle.
module rr_req_arbiter #(
  parameter int unsigned ID_W     = 2,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_req_arbiter_if.slave  bus
);
  localparam int unsigned REQ_NUM = 32'(1) << ID_W;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q, state_d;
  logic [REQ_NUM-1:0] gnt_q, gnt_d;
  logic               gnt_vld_q, gnt_vld_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]    last_id_q, last_id_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               timeout_q, timeout_d;

  logic               any_req;
  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic               owner_rel;
  logic               hold_lim;

  assign any_req   = |bus.req;
  assign owner_rel = bus.done[gnt_id_q] | ~bus.req[gnt_id_q];
  assign hold_lim  = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

  // Winner search: first set request after last_id, wrapping modulo REQ_NUM.
  always_comb begin
    logic [ID_W-1:0] idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int unsigned k = 1; k <= REQ_NUM; k++) begin
      idx = last_id_q + ID_W'(k);
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_vld_q  <= 1'b0;
      gnt_id_q   <= '0;
      last_id_q  <= '1;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_vld_q  <= gnt_vld_d;
      gnt_id_q   <= gnt_id_d;
      last_id_q  <= last_id_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state: any release (done, drop, or hold limit) returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = GRANT;
      GRANT:   if (owner_rel || hold_lim) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs: grant, owner index, hold counter and timeout pulse.
  always_comb begin
    gnt_d      = '0;
    gnt_id_d   = gnt_id_q;
    last_id_d  = last_id_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d      = REQ_NUM'(1) << win_id;
          gnt_id_d   = win_id;
          last_id_d  = win_id;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (owner_rel) begin
          gnt_d = '0;
        end else if (hold_lim) begin
          timeout_d = 1'b1;
        end else begin
          gnt_d      = gnt_q;
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: gnt_d = '0;
    endcase
    gnt_vld_d = |gnt_d;
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_vld = gnt_vld_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.timeout = timeout_q;
  assign bus.busy    = any_req | gnt_vld_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed bench for rr_req_arbiter (ID_W=2, MAX_HOLD=8).
module tb_rr_req_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rr_req_arbiter_if #(.ID_W(2)) bus ();

  rr_req_arbiter #(.ID_W(2), .MAX_HOLD(8), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         exp_seq [5];
    logic [3:0] oh;
    exp_seq = '{0, 1, 2, 3, 0};

    // Reset with all requests high.
    rst_n    = 1'b0;
    bus.req  = 4'b1111;
    bus.done = 4'b0000;
    tick();
    tick();
    check_eq("rst_gnt", 32'(bus.gnt), 32'h0);
    check_eq("rst_vld", 32'(bus.gnt_vld), 32'h0);
    check_eq("rst_id", 32'(bus.gnt_id), 32'h0);
    check_eq("rst_timeout", 32'(bus.timeout), 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h1);

    // Release reset: first sampled edge grants requester 0.
    rst_n = 1'b1;
    tick();

    // Round-robin with all requests held, done pulsed by each owner.
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << exp_seq[i];
      check_eq("rr_gnt", 32'(bus.gnt), 32'(oh));
      check_eq("rr_id", 32'(bus.gnt_id), 32'(exp_seq[i]));
      check_eq("rr_vld", 32'(bus.gnt_vld), 32'h1);
      tick();
      check_eq("rr_hold", 32'(bus.gnt), 32'(oh));
      bus.done = oh;
      tick();
      bus.done = 4'b0000;
      check_eq("rr_gap", 32'(bus.gnt), 32'h0);
      check_eq("rr_gap_to", 32'(bus.timeout), 32'h0);
      tick();
    end
    // Requester 1 now owns; it drops its request.
    check_eq("own1_gnt", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0000;
    tick();
    check_eq("drop_gnt", 32'(bus.gnt), 32'h0);
    check_eq("drop_to", 32'(bus.timeout), 32'h0);

    // Make 3 the last owner, then wrap to 0 with req=0101.
    bus.req = 4'b1000;
    tick();
    check_eq("own3_gnt", 32'(bus.gnt), 32'h8);
    bus.req = 4'b0101;
    tick();
    check_eq("own3_rel", 32'(bus.gnt), 32'h0);
    tick();
    check_eq("wrap_gnt", 32'(bus.gnt), 32'h1);
    check_eq("wrap_id", 32'(bus.gnt_id), 32'h0);
    bus.done = 4'b0001;
    tick();
    bus.done = 4'b0000;
    check_eq("wrap_rel", 32'(bus.gnt), 32'h0);
    tick();
    check_eq("skip_gnt", 32'(bus.gnt), 32'h4);
    check_eq("skip_id", 32'(bus.gnt_id), 32'h2);

    // Done from non-owners is ignored.
    bus.done = 4'b1011;
    tick();
    bus.done = 4'b0000;
    check_eq("nonown_done", 32'(bus.gnt), 32'h4);

    // Run to the last hold cycle, then done and limit on the same edge.
    for (int c = 0; c < 6; c++) begin
      tick();
      check_eq("hold2_gnt", 32'(bus.gnt), 32'h4);
    end
    bus.done = 4'b0100;
    tick();
    bus.done = 4'b0000;
    check_eq("done_lim_gnt", 32'(bus.gnt), 32'h0);
    check_eq("done_lim_to", 32'(bus.timeout), 32'h0);
    tick();
    check_eq("after2_gnt", 32'(bus.gnt), 32'h1);

    // Hold limit: requester 1 alone, no done.
    bus.req = 4'b0010;
    tick();
    check_eq("own0_rel", 32'(bus.gnt), 32'h0);
    tick();
    for (int c = 0; c < 8; c++) begin
      check_eq("lim_gnt", 32'(bus.gnt), 32'h2);
      check_eq("lim_to_low", 32'(bus.timeout), 32'h0);
      tick();
    end
    check_eq("lim_rel_gnt", 32'(bus.gnt), 32'h0);
    check_eq("lim_rel_to", 32'(bus.timeout), 32'h1);
    check_eq("lim_busy", 32'(bus.busy), 32'h1);
    tick();
    check_eq("lim_regnt", 32'(bus.gnt), 32'h2);
    check_eq("lim_to_pulse", 32'(bus.timeout), 32'h0);

    // Mid-grant reset during a grant to requester 2.
    bus.req = 4'b0100;
    tick();
    check_eq("pre_rst_rel", 32'(bus.gnt), 32'h0);
    tick();
    check_eq("pre_rst_gnt", 32'(bus.gnt), 32'h4);
    rst_n   = 1'b0;
    bus.req = 4'b0101;
    tick();
    check_eq("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    check_eq("mid_rst_id", 32'(bus.gnt_id), 32'h0);
    check_eq("mid_rst_to", 32'(bus.timeout), 32'h0);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_gnt", 32'(bus.gnt), 32'h1);
    check_eq("post_rst_id", 32'(bus.gnt_id), 32'h0);

    // Fully idle: busy and gnt_vld low.
    bus.req = 4'b0000;
    tick();
    tick();
    check_eq("idle_busy", 32'(bus.busy), 32'h0);
    check_eq("idle_vld", 32'(bus.gnt_vld), 32'h0);
    check_eq("idle_id_hold", 32'(bus.gnt_id), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
